edge_event_sequencer: RTL and testbench

//  Cycle-based controller for SV event-control semantics: waits for N qualified events on a

---
 rtl/edge_event_sequencer.sv | 66 ++++++
 tb/tb_edge_event_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/edge_event_sequencer.sv
// edge_event_sequencer: counts qualified change/edge events on sig, waits a post-delay, then pulses done
module edge_event_sequencer #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8,
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [DLY_W-1:0] delay,
  input  logic [WIDTH-1:0] sig,
  input  logic             iff_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] events_seen
);
  typedef enum logic [1:0] {IDLE, WAIT, DELAY, DONE} state_t;
  state_t state, state_n;
  logic [1:0] mode_q;
  logic [CNT_W-1:0] rem;
  logic [DLY_W-1:0] dcnt;
  logic [WIDTH-1:0] prev;
  logic ev;
  always_comb begin
    ev = iff_en & (mode_q == 2'd0 ? sig != prev :
                   mode_q == 2'd1 ? ~prev[0] & sig[0] :
                   mode_q == 2'd2 ? prev[0] & ~sig[0] : prev[0] ^ sig[0]);
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = count != '0 ? WAIT : delay != '0 ? DELAY : DONE;
      WAIT:    if (abort) state_n = IDLE;
               else if (ev && rem == CNT_W'(1)) state_n = dcnt != '0 ? DELAY : DONE;
      DELAY:   state_n = abort ? IDLE : dcnt == DLY_W'(1) ? DONE : DELAY;
      default: state_n = IDLE;
    endcase
  end
  assign busy = state == WAIT || state == DELAY;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= '0;
      rem         <= '0;
      dcnt        <= '0;
      prev        <= '0;
      events_seen <= '0;
    end else begin
      state <= state_n;
      prev  <= sig;
      if (state == IDLE && start) begin
        mode_q      <= mode;
        rem         <= count;
        dcnt        <= delay;
        events_seen <= '0;
      end
      if (state == WAIT && ev && !abort) begin
        rem <= rem - CNT_W'(1);
        if (events_seen != '1) events_seen <= events_seen + CNT_W'(1);
      end
      if (state == DELAY) dcnt <= dcnt - DLY_W'(1);
    end
  end
endmodule

// File: tb/tb_edge_event_sequencer.sv
// tb_edge_event_sequencer: table, directed and random checks against a timestamp-based reference model
module tb_edge_event_sequencer;
  localparam int W = 96;
  logic clk = 1'b0;
  logic rst, start, abort, iff_en;
  logic [1:0] mode;
  logic [7:0] count, delay;
  logic [W-1:0] sig;
  logic busy, done;
  logic [7:0] events_seen;
  always #5 clk = ~clk;
  edge_event_sequencer #(.WIDTH(W), .CNT_W(8), .DLY_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .count(count),
    .delay(delay), .sig(sig), .iff_en(iff_en), .busy(busy), .done(done), .events_seen(events_seen)
  );
  int checks = 0, errors = 0, cyc = 0;
  bit m_act = 0;
  int m_done_at = -1, m_need = 0, m_seen = 0, m_dly = 0;
  logic [1:0] m_mode = 2'd0;
  logic [W-1:0] m_prev = '0;
  typedef struct {int st, md, cn, dl, s0, ie, eb, ed, ees;} vec_t;
  vec_t tbl[21];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask
  function automatic bit is_ev(input logic [1:0] md, input logic [W-1:0] p, input logic [W-1:0] s);
    case (md)
      2'd0:    return p != s;
      2'd1:    return p[0] == 1'b0 && s[0] == 1'b1;
      2'd2:    return p[0] == 1'b1 && s[0] == 1'b0;
      default: return p[0] != s[0];
    endcase
  endfunction
  function automatic logic [W-1:0] b0(input logic x);
    return {{(W-1){1'b0}}, x};
  endfunction
  task automatic step(input logic rs, input logic st, input logic ab, input logic [1:0] md,
                      input logic [7:0] cn, input logic [7:0] dl, input logic [W-1:0] sg, input logic ie);
    rst = rs; start = st; abort = ab; mode = md; count = cn; delay = dl; sig = sg; iff_en = ie;
    chk("busy", int'(busy), int'(m_act && (m_done_at < 0 || cyc < m_done_at)));
    chk("done", int'(done), int'(m_act && cyc == m_done_at));
    chk("events_seen", int'(events_seen), m_seen);
    if (rs) begin
      m_act = 0; m_seen = 0; m_done_at = -1;
    end else if (!m_act) begin
      if (st) begin
        m_act = 1; m_mode = md; m_need = int'(cn); m_dly = int'(dl); m_seen = 0;
        m_done_at = cn == 8'd0 ? cyc + 1 + int'(dl) : -1;
      end
    end else if (cyc == m_done_at) m_act = 0;
    else if (ab) m_act = 0;
    else if (m_done_at < 0 && ie && is_ev(m_mode, m_prev, sg)) begin
      m_seen++;
      if (m_seen == m_need) m_done_at = cyc + 1 + m_dly;
    end
    m_prev = rs ? '0 : sg;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W-1:0] rsig;
    tbl = '{
      '{1,1,1,0,0,1,0,0,0}, '{0,1,1,0,0,1,1,0,0}, '{0,1,1,0,0,1,1,0,0}, '{0,1,1,0,0,1,1,0,0},
      '{0,1,1,0,0,1,1,0,0}, '{0,1,1,0,1,1,1,0,0}, '{0,1,1,0,1,1,0,1,1}, '{0,1,1,0,1,1,0,0,1},
      '{1,3,3,4,0,1,0,0,1}, '{0,3,3,4,0,1,1,0,0}, '{0,3,3,4,1,1,1,0,0}, '{0,3,3,4,1,1,1,0,1},
      '{0,3,3,4,0,1,1,0,1}, '{0,3,3,4,0,1,1,0,2}, '{0,3,3,4,1,1,1,0,2}, '{0,3,3,4,1,1,1,0,3},
      '{0,3,3,4,1,1,1,0,3}, '{0,3,3,4,1,1,1,0,3}, '{0,3,3,4,1,1,1,0,3}, '{0,3,3,4,1,1,0,1,3},
      '{0,3,3,4,1,1,0,0,3}
    };
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; count = 8'd0; delay = 8'd0; sig = '0; iff_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_events", int'(events_seen), 0);
    for (int i = 0; i < 21; i++) begin
      chk("tbl_busy", int'(busy), tbl[i].eb);
      chk("tbl_done", int'(done), tbl[i].ed);
      chk("tbl_events", int'(events_seen), tbl[i].ees);
      step(1'b0, 1'(tbl[i].st), 1'b0, 2'(tbl[i].md), 8'(tbl[i].cn), 8'(tbl[i].dl), b0(1'(tbl[i].s0)), 1'(tbl[i].ie));
    end
    for (int k = 0; k < 14; k++) begin
      if (k == 4) chk("t3_gated_edge", int'(events_seen), 0);
      if (k == 8) chk("t3_first_event", int'(events_seen), 1);
      if (k == 11) chk("t3_not_yet", int'(done), 0);
      if (k == 12) begin
        chk("t3_done", int'(done), 1);
        chk("t3_events", int'(events_seen), 2);
      end
      step(1'b0, k == 0, 1'b0, 2'd1, 8'd2, 8'd0,
           b0((k >= 3 && k < 5) || (k >= 7 && k < 9) || k >= 11), k != 3);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 4) chk("t4_wide_busy", int'(busy), 1);
      if (k == 5) chk("t4_wide_done", int'(done), 1);
      step(1'b0, k == 0, 1'b0, 2'd0, 8'd1, 8'd0, k >= 4 ? (W'(1) << 64) : '0, 1'b1);
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        chk("t4_neg_busy", int'(busy), 1);
        chk("t4_neg_events", int'(events_seen), 0);
      end
      step(1'b0, k == 0, k == 8, 2'd2, 8'd1, 8'd0, b0(k >= 2), 1'b1);
    end
    chk("t4_abort_idle", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) chk("t5_zero_done", int'(done), 1);
      step(1'b0, k == 0, 1'b0, 2'd1, 8'd0, 8'd0, '0, 1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 3) chk("t5_delay_busy", int'(busy), 1);
      if (k == 4) chk("t5_delay_done", int'(done), 1);
      step(1'b0, k == 0, 1'b0, 2'd1, 8'd0, 8'd3, '0, 1'b1);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 7) begin
        chk("t6_abort_busy", int'(busy), 0);
        chk("t6_abort_done", int'(done), 0);
        chk("t6_abort_events", int'(events_seen), 2);
      end
      step(1'b0, k == 0 || k == 3, k == 6, k == 3 ? 2'd3 : 2'd1, k == 3 ? 8'd1 : 8'd5, 8'd0,
           b0(k == 2 || k == 4), 1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_events", int'(events_seen), 0);
      end
      step(k == 3, k == 0, 1'b0, 2'd1, 8'd5, 8'd0, b0(k == 2), 1'b1);
    end
    rsig = '0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) rsig[0] = ~rsig[0];
      if ($urandom_range(0, 9) == 0) rsig = rsig ^ (W'(1) << $urandom_range(0, W - 1));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0,
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)),
           rsig, $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
